// File: rtl/bus85_pkg.sv
// bus85_pkg: shared types and constants for the bus85 memory slave.
//   state_t      - access FSM encoding (IDLE/WAIT/READ/WRITE)
//   DATASIZE_DEF - default AD/data bus width
//   ADDRSIZE_DEF - default full address width
//   CNTW         - wait-state counter width (supports 0..15 wait states)
package bus85_pkg;

    localparam int unsigned DATASIZE_DEF = 8;
    localparam int unsigned ADDRSIZE_DEF = 16;
    localparam int unsigned CNTW         = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/bus85_ram.sv
// bus85_ram: single-port synchronous RAM, 2**MEMSIZE x DATASIZE.
// Ports:
//   clk   - clock
//   rst_  - async active-low reset (clears the read register only, not the array)
//   addr  - word address
//   re    - read enable; rdata <= mem[addr] on the next edge
//   we    - write enable; mem[addr] <= wdata on the next edge
//   wdata - write data
//   rdata - registered read data (holds while re=0)
module bus85_ram
    import bus85_pkg::*;
#(
    parameter int unsigned DATASIZE = DATASIZE_DEF,
    parameter int unsigned MEMSIZE  = 12
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic [MEMSIZE-1:0]  addr,
    input  logic                re,
    input  logic                we,
    input  logic [DATASIZE-1:0] wdata,
    output logic [DATASIZE-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << MEMSIZE;

    logic [DATASIZE-1:0] mem [DEPTH];

    // Array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/bus85_mem.sv
// bus85_mem: memory-side slave for the multiplexed 8085 bus from core85.
// Latches the address on ALE, decodes a 2**MEMSIZE window at MEMBASE,
// stretches T2 with WAITST wait states via READY, and serves reads /
// commits writes from an internal synchronous RAM.
// Ports:
//   clk, rst_        - clock, async active-low reset
//   ale, ad_in, addr - address latch enable, AD bus in, upper address
//   iom_, rd_, wr_   - I/O-not-memory, read and write strobes (active-low)
//   ad_out, ad_oe    - read data and its drive enable
//   ready            - 0 stretches the bus cycle
//   sel              - access to this window in progress
//   bus_err          - one-clock pulse on rd_/wr_ both low (or protected write)
// Optional: define BUS85_MEM_WPROT_EN to add WPTOP; writes below
// MEMBASE+WPTOP complete on the bus but leave the RAM untouched.
module bus85_mem
    import bus85_pkg::*;
#(
    parameter int unsigned          DATASIZE = DATASIZE_DEF,
    parameter int unsigned          ADDRSIZE = ADDRSIZE_DEF,
    parameter int unsigned          MEMSIZE  = 12,
    parameter logic [ADDRSIZE-1:0]  MEMBASE  = 16'h0000,
    parameter int unsigned          WAITST   = 1
`ifdef BUS85_MEM_WPROT_EN
    ,
    parameter logic [ADDRSIZE-1:0]  WPTOP    = 16'h0800
`endif
) (
    input  logic                         clk,
    input  logic                         rst_,
    input  logic                         ale,
    input  logic [DATASIZE-1:0]          ad_in,
    output logic [DATASIZE-1:0]          ad_out,
    output logic                         ad_oe,
    input  logic [ADDRSIZE-DATASIZE-1:0] addr,
    input  logic                         iom_,
    input  logic                         rd_,
    input  logic                         wr_,
    output logic                         ready,
    output logic                         sel,
    output logic                         bus_err
);

    state_t                state_q, state_d;
    logic [ADDRSIZE-1:0]   lat_q;
    logic [MEMSIZE-1:0]    off_q, off_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic [DATASIZE-1:0]   wdat_q, wdat_d;
    logic                  is_wr_q, is_wr_d;
    logic                  ready_d, sel_d, ad_oe_d, bus_err_d;
    logic                  ram_re, ram_we;
    logic                  hit;
    logic                  wp_q;

`ifdef BUS85_MEM_WPROT_EN
    localparam logic [ADDRSIZE-1:0] WP_LIMIT = MEMBASE + WPTOP;
    logic wp_d;
`else
    assign wp_q = 1'b0;
`endif

    assign hit = !iom_ && (lat_q[ADDRSIZE-1:MEMSIZE] == MEMBASE[ADDRSIZE-1:MEMSIZE]);

    // Address latch; a mid-access ALE only refreshes this, never off_q.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            lat_q <= '0;
        end else if (ale) begin
            lat_q <= {addr, ad_in};
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        off_d     = off_q;
        cnt_d     = cnt_q;
        is_wr_d   = is_wr_q;
        ready_d   = 1'b1;
        sel_d     = sel;
        ad_oe_d   = 1'b0;
        bus_err_d = 1'b0;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        // Tracks the AD bus while wr_ is low, so the commit uses the last low-phase value.
        wdat_d    = wr_ ? wdat_q : ad_in;
`ifdef BUS85_MEM_WPROT_EN
        wp_d      = wp_q;
`endif
        case (state_q)
            ST_IDLE: begin
                sel_d = 1'b0;
                if (!rd_ && !wr_) begin
                    bus_err_d = 1'b1;
                end else if (hit && (!rd_ || !wr_)) begin
                    off_d   = lat_q[MEMSIZE-1:0];
                    sel_d   = 1'b1;
                    is_wr_d = !wr_;
`ifdef BUS85_MEM_WPROT_EN
                    wp_d    = (lat_q < WP_LIMIT);
`endif
                    if (WAITST == 0) begin
                        state_d = !wr_ ? ST_WRITE : ST_READ;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNTW'(WAITST - 1);
                        ready_d = 1'b0;
                    end
                end
            end
            ST_WAIT: begin
                if (is_wr_q ? wr_ : rd_) begin
                    // Strobe withdrawn before the data phase: abandon the access.
                    state_d = ST_IDLE;
                    sel_d   = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = is_wr_q ? ST_WRITE : ST_READ;
                end else begin
                    cnt_d   = cnt_q - CNTW'(1);
                    ready_d = 1'b0;
                end
            end
            ST_READ: begin
                ram_re = 1'b1;
                if (rd_) begin
                    state_d = ST_IDLE;
                    sel_d   = 1'b0;
                end else begin
                    ad_oe_d = 1'b1;
                end
            end
            ST_WRITE: begin
                if (wr_) begin
                    ram_we    = !wp_q;
                    bus_err_d = wp_q;
                    state_d   = ST_IDLE;
                    sel_d     = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= ST_IDLE;
            off_q   <= '0;
            cnt_q   <= '0;
            wdat_q  <= '0;
            is_wr_q <= 1'b0;
            ready   <= 1'b1;
            sel     <= 1'b0;
            ad_oe   <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            wdat_q  <= wdat_d;
            is_wr_q <= is_wr_d;
            ready   <= ready_d;
            sel     <= sel_d;
            ad_oe   <= ad_oe_d;
            bus_err <= bus_err_d;
        end
    end

`ifdef BUS85_MEM_WPROT_EN
    // Protection decision is taken at access start, immune to mid-cycle ALE.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wp_q <= 1'b0;
        end else begin
            wp_q <= wp_d;
        end
    end
`endif

    bus85_ram #(
        .DATASIZE (DATASIZE),
        .MEMSIZE  (MEMSIZE)
    ) u_ram (
        .clk   (clk),
        .rst_  (rst_),
        .addr  (off_q),
        .re    (ram_re),
        .we    (ram_we),
        .wdata (wdat_q),
        .rdata (ad_out)
    );

endmodule

// File: tb/tb_bus85_mem.sv
// Directed bench for bus85_mem. u_dut: window 0x0000, 1 wait state.
// u_dut3: window 0x2000, 3 wait states. Both share the same bus inputs.
module tb_bus85_mem;

    logic       clk = 1'b0;
    logic       rst_ = 1'b1;
    logic       ale = 1'b0;
    logic [7:0] ad_in = 8'h00;
    logic [7:0] addr = 8'h00;
    logic       iom_ = 1'b0;
    logic       rd_ = 1'b1;
    logic       wr_ = 1'b1;

    logic [7:0] ad_out1, ad_out3;
    logic       ad_oe1, ad_oe3, ready1, ready3, sel1, sel3, err1, err3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus85_mem #(
        .MEMBASE (16'h0000),
        .WAITST  (1)
`ifdef BUS85_MEM_WPROT_EN
        , .WPTOP (16'h0000)
`endif
    ) u_dut (
        .clk (clk), .rst_ (rst_), .ale (ale), .ad_in (ad_in),
        .ad_out (ad_out1), .ad_oe (ad_oe1), .addr (addr), .iom_ (iom_),
        .rd_ (rd_), .wr_ (wr_), .ready (ready1), .sel (sel1), .bus_err (err1)
    );

    bus85_mem #(
        .MEMBASE (16'h2000),
        .WAITST  (3)
    ) u_dut3 (
        .clk (clk), .rst_ (rst_), .ale (ale), .ad_in (ad_in),
        .ad_out (ad_out3), .ad_oe (ad_oe3), .addr (addr), .iom_ (iom_),
        .rd_ (rd_), .wr_ (wr_), .ready (ready3), .sel (sel3), .bus_err (err3)
    );

`ifdef BUS85_MEM_WPROT_EN
    logic [7:0] ad_outw;
    logic       ad_oew, readyw, selw, errw;

    bus85_mem #(
        .MEMBASE (16'h0000),
        .WAITST  (1)
    ) u_dutw (
        .clk (clk), .rst_ (rst_), .ale (ale), .ad_in (ad_in),
        .ad_out (ad_outw), .ad_oe (ad_oew), .addr (addr), .iom_ (iom_),
        .rd_ (rd_), .wr_ (wr_), .ready (readyw), .sel (selw), .bus_err (errw)
    );
`endif

    function automatic logic rdy(input int w);
        case (w)
            1: return ready3;
`ifdef BUS85_MEM_WPROT_EN
            2: return readyw;
`endif
            default: return ready1;
        endcase
    endfunction

    function automatic logic [7:0] dout(input int w);
        case (w)
            1: return ad_out3;
`ifdef BUS85_MEM_WPROT_EN
            2: return ad_outw;
`endif
            default: return ad_out1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_latch(input logic [15:0] a, input logic io);
        ale   = 1'b1;
        addr  = a[15:8];
        ad_in = a[7:0];
        iom_  = io;
        tick();
        ale   = 1'b0;
        ad_in = 8'h00;
    endtask

    task automatic wait_ready(input int w, input string name);
        for (int i = 0; i < 20 && rdy(w) !== 1'b1; i++) tick();
        if (rdy(w) !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: ready=%b after 20 clocks, required 1", name, rdy(w));
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d0,
                            input logic [7:0] d1, input int w);
        do_latch(a, 1'b0);
        wr_   = 1'b0;
        ad_in = d0;
        tick();
        wait_ready(w, "write_ready");
        ad_in = d1;
        tick();
        wr_ = 1'b1;
        tick();
        ad_in = 8'h00;
    endtask

    task automatic do_read(input logic [15:0] a, input int w, output logic [7:0] d);
        do_latch(a, 1'b0);
        rd_ = 1'b0;
        tick();
        wait_ready(w, "read_ready");
        tick();
        d   = dout(w);
        rd_ = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #2 rst_ = 1'b0;
        #2;
        checks += 6;
        if (ready1 !== 1'b1)   begin errors++; $display("FAIL rst_ready: got %b want 1", ready1); end
        if (ad_oe1 !== 1'b0)   begin errors++; $display("FAIL rst_ad_oe: got %b want 0", ad_oe1); end
        if (ad_out1 !== 8'h00) begin errors++; $display("FAIL rst_ad_out: got %h want 00", ad_out1); end
        if (sel1 !== 1'b0)     begin errors++; $display("FAIL rst_sel: got %b want 0", sel1); end
        if (err1 !== 1'b0)     begin errors++; $display("FAIL rst_bus_err: got %b want 0", err1); end
        if (ready3 !== 1'b1)   begin errors++; $display("FAIL rst_ready3: got %b want 1", ready3); end
        tick();
        tick();
        rst_ = 1'b1;
        tick();
    endtask

    task automatic test_read_wait();
        do_write(16'h0010, 8'h11, 8'h3E, 0);
        do_latch(16'h0010, 1'b0);
        rd_ = 1'b0;
        tick();
        checks++;
        if (ready1 !== 1'b0 || sel1 !== 1'b1) begin
            errors++; $display("FAIL rd_wait: ready=%b sel=%b want 0/1", ready1, sel1);
        end
        tick();
        checks++;
        if (ready1 !== 1'b1 || ad_oe1 !== 1'b0) begin
            errors++; $display("FAIL rd_entry: ready=%b ad_oe=%b want 1/0", ready1, ad_oe1);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (ad_oe1 !== 1'b1 || ad_out1 !== 8'h3E || ready1 !== 1'b1) begin
                errors++;
                $display("FAIL rd_data: ad_oe=%b ad_out=%h ready=%b want 1/3e/1", ad_oe1, ad_out1, ready1);
            end
        end
        rd_ = 1'b1;
        tick();
        checks++;
        if (ad_oe1 !== 1'b0 || sel1 !== 1'b0) begin
            errors++; $display("FAIL rd_end: ad_oe=%b sel=%b want 0/0", ad_oe1, sel1);
        end
    endtask

    task automatic test_write();
        logic [7:0] d;
        do_write(16'h0123, 8'h5A, 8'hA5, 0);
        do_read(16'h0123, 0, d);
        checks++;
        if (d !== 8'hA5) begin errors++; $display("FAIL wr_readback: got %h want a5", d); end
    endtask

    task automatic test_io_miss();
        do_latch(16'h0010, 1'b1);
        rd_ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ready1 !== 1'b1 || ad_oe1 !== 1'b0 || sel1 !== 1'b0) begin
                errors++;
                $display("FAIL io_quiet: ready=%b ad_oe=%b sel=%b want 1/0/0", ready1, ad_oe1, sel1);
            end
        end
        rd_  = 1'b1;
        iom_ = 1'b0;
        tick();
        // 0x0010 lies outside the 0x2000 window of u_dut3.
        do_latch(16'h0010, 1'b0);
        rd_ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ready3 !== 1'b1 || ad_oe3 !== 1'b0 || sel3 !== 1'b0) begin
                errors++;
                $display("FAIL miss_quiet: ready=%b ad_oe=%b sel=%b want 1/0/0", ready3, ad_oe3, sel3);
            end
        end
        rd_ = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_illegal();
        logic [7:0] d;
        do_write(16'h0200, 8'h00, 8'h42, 0);
        do_latch(16'h0200, 1'b0);
        rd_   = 1'b0;
        wr_   = 1'b0;
        ad_in = 8'h99;
        tick();
        checks++;
        if (err1 !== 1'b1 || ready1 !== 1'b1 || sel1 !== 1'b0) begin
            errors++;
            $display("FAIL ill_pulse: bus_err=%b ready=%b sel=%b want 1/1/0", err1, ready1, sel1);
        end
        rd_   = 1'b1;
        wr_   = 1'b1;
        ad_in = 8'h00;
        tick();
        checks++;
        if (err1 !== 1'b0) begin errors++; $display("FAIL ill_clear: bus_err=%b want 0", err1); end
        do_read(16'h0200, 0, d);
        checks++;
        if (d !== 8'h42) begin errors++; $display("FAIL ill_ram: got %h want 42", d); end
    endtask

    task automatic test_mid_ale();
        do_latch(16'h0123, 1'b0);
        rd_ = 1'b0;
        tick();
        ale   = 1'b1;
        addr  = 8'h00;
        ad_in = 8'h10;
        tick();
        ale   = 1'b0;
        ad_in = 8'h00;
        tick();
        checks++;
        if (ad_oe1 !== 1'b1 || ad_out1 !== 8'hA5) begin
            errors++; $display("FAIL mid_ale: ad_oe=%b ad_out=%h want 1/a5", ad_oe1, ad_out1);
        end
        rd_ = 1'b1;
        tick();
    endtask

    task automatic test_abort();
        logic [7:0] d;
        do_write(16'h2020, 8'h00, 8'h55, 1);
        do_latch(16'h2020, 1'b0);
        wr_   = 1'b0;
        ad_in = 8'hEE;
        tick();
        tick();
        wr_ = 1'b1;
        tick();
        checks++;
        if (ready3 !== 1'b1 || sel3 !== 1'b0) begin
            errors++; $display("FAIL abort: ready=%b sel=%b want 1/0", ready3, sel3);
        end
        ad_in = 8'h00;
        tick();
        do_read(16'h2020, 1, d);
        checks++;
        if (d !== 8'h55) begin errors++; $display("FAIL abort_ram: got %h want 55", d); end
    endtask

    task automatic test_reset_mid_wait();
        logic [7:0] d;
        do_write(16'h2010, 8'h00, 8'hC3, 1);
        do_latch(16'h2010, 1'b0);
        rd_ = 1'b0;
        tick();
        tick();
        checks++;
        if (ready3 !== 1'b0 || sel1 !== 1'b0) begin
            errors++; $display("FAIL wait3: ready3=%b sel=%b want 0/0", ready3, sel1);
        end
        #2 rst_ = 1'b0;
        #1;
        checks++;
        if (ready3 !== 1'b1 || ad_oe3 !== 1'b0 || sel3 !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: ready=%b ad_oe=%b sel=%b want 1/0/0", ready3, ad_oe3, sel3);
        end
        rd_ = 1'b1;
        tick();
        tick();
        rst_ = 1'b1;
        tick();
        do_read(16'h2010, 1, d);
        checks++;
        if (d !== 8'hC3) begin errors++; $display("FAIL rst_ram3: got %h want c3", d); end
        do_read(16'h0123, 0, d);
        checks++;
        if (d !== 8'hA5) begin errors++; $display("FAIL rst_ram1: got %h want a5", d); end
    endtask

`ifdef BUS85_MEM_WPROT_EN
    task automatic test_wprot();
        logic [7:0] d;
        do_latch(16'h0400, 1'b0);
        wr_   = 1'b0;
        ad_in = 8'h77;
        tick();
        tick();
        tick();
        wr_ = 1'b1;
        tick();
        checks++;
        if (errw !== 1'b1) begin errors++; $display("FAIL wp_err: bus_err=%b want 1", errw); end
        ad_in = 8'h00;
        tick();
        checks++;
        if (errw !== 1'b0) begin errors++; $display("FAIL wp_err_clear: bus_err=%b want 0", errw); end
        do_read(16'h0400, 2, d);
        checks++;
        if (d === 8'h77) begin errors++; $display("FAIL wp_ram: got %h, must not be 77", d); end
        do_write(16'h0900, 8'h00, 8'h5C, 2);
        do_read(16'h0900, 2, d);
        checks++;
        if (d !== 8'h5C) begin errors++; $display("FAIL wp_open: got %h want 5c", d); end
    endtask
`endif

    initial begin
        test_reset();
        test_read_wait();
        test_write();
        test_io_miss();
        test_illegal();
        test_mid_ale();
        test_abort();
        test_reset_mid_wait();
`ifdef BUS85_MEM_WPROT_EN
        test_wprot();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/bus85_mem.md
Name: bus85_mem

Overview:
- Memory-side bus slave that sits directly downstream of core85 and consumes its multiplexed 8085 bus (ALE, AD, A, IO/M_, RD_, WR_).
- Demultiplexes the address and decodes a memory window.
- Inserts programmable wait states through READY.
- Serves reads from, and commits writes into, an internal synchronous RAM array. This replaces the behavioural memory model in system-level simulation and synthesis.

Parameters:
- DATASIZE, 8, data/AD bus width
- ADDRSIZE, 16, full address width
- MEMSIZE, 12, log2 of RAM depth in words (4 KiB default)
- MEMBASE, 16'h0000, window base address; must be aligned to 2**MEMSIZE
- WAITST, 1, wait-state clocks inserted per access (0..15)

Ports:
- clk  in  1  system clock; core85 clk_out domain
- rst_  in  1  asynchronous, active-low reset
- ale  in  1  address latch enable from core85
- ad_in  in  DATASIZE  AD bus as driven by core85
- ad_out  out  DATASIZE  read data toward AD bus
- ad_oe  out  1  tri-state enable for ad_out (1 = drive)
- addr  in  ADDRSIZE-DATASIZE  upper address A[15:8]
- iom_  in  1  0 = memory cycle, 1 = I/O
- rd_  in  1  read strobe, active-low
- wr_  in  1  write strobe, active-low
- ready  out  1  to core85 READY; 0 stretches T2
- sel  out  1  1 while an access to this window is in progress
- bus_err  out  1  one-clock pulse on illegal strobe combination

Behaviour:
- Reset (rst_=0, asynchronous):
  - FSM to IDLE; ready=1, ad_oe=0, ad_out=0, sel=0, bus_err=0.
  - Address latch and wait counter cleared.
  - RAM contents are not cleared.
- Address latch: on each posedge clk with ale=1, lat <= {addr, ad_in}. Holds while ale=0.
- Hit: iom_==0 and lat[ADDRSIZE-1:MEMSIZE] == MEMBASE[ADDRSIZE-1:MEMSIZE].
- FSM states: IDLE, WAIT, READ, WRITE.
  - IDLE, hit, rd_=0, wr_=1:
    - capture offset off = lat[MEMSIZE-1:0]; sel=1.
    - if WAITST=0, go to READ; else go to WAIT with cnt=WAITST-1 and ready=0 (registered, same edge).
  - IDLE, hit, wr_=0, rd_=1: as above, but the target state is WRITE.
  - IDLE, rd_=0 and wr_=0 together: stay IDLE; bus_err=1 for one clock.
  - IDLE, miss or iom_=1: stay IDLE, ready=1, no drive.
  - WAIT: ready=0; cnt decrements each clock. At cnt==0, go to READ or WRITE, ready=1 on the same edge.
  - READ:
    - ad_out <= mem[off] (registered, one-clock read latency from READ entry); ad_oe=1 from the clock after READ entry.
    - when rd_ is sampled 1: ad_oe=0 and sel=0 on that edge, go to IDLE.
  - WRITE:
    - every clock with wr_=0, wdat <= ad_in.
    - on the first clock wr_ is sampled 1 (rising edge): mem[off] <= wdat, sel=0, go to IDLE.
    - the data written is the last value captured while wr_ was low.
- Mid-cycle ALE: an ale pulse during WAIT, READ or WRITE updates the latch only. The current access completes using the captured off.
- Strobe released during WAIT: abort to IDLE, ready=1, no RAM write.
- Window wrap: the offset is the low MEMSIZE bits only. No wrap into adjacent windows occurs because of the hit check.

Optional Feature:
- BUS85_MEM_WPROT_EN:
  - when defined, adds parameter WPTOP (default 16'h0800).
  - writes with lat < MEMBASE+WPTOP are completed on the bus (normal ready timing) but the RAM is not updated, and bus_err pulses on the commit clock.
  - when undefined, the whole window is writable and no protection logic exists.

Decomposition:
- Package bus85_pkg:
  - FSM state typedef (IDLE/WAIT/READ/WRITE, 2-bit)
  - DATASIZE/ADDRSIZE defaults
  - helper constant for the WAITST counter width (4)
- One natural sub-module, bus85_ram: single-port synchronous RAM (registered read, write enable), 2**MEMSIZE x DATASIZE, owning the array.

Test Plan:
- Read with WAITST=1: mem[0x0010]=0x3E; ALE latches 0x0010; rd_ low.
  - Required: ready=0 for exactly one clock; ad_oe=1, ad_out=0x3E until rd_ high; then ad_oe=0 next edge.
- Write: ALE 0x0123; wr_ low with ad_in=0x5A, then 0xA5 in the last low clock.
  - Required: mem[0x123]=0xA5 after the wr_ rising edge; a following read returns 0xA5.
- I/O and miss: iom_=1 at 0x0010, or MEMBASE=0x2000 with access to 0x0010.
  - Required: ready stays 1, ad_oe stays 0, sel stays 0.
- Illegal strobes: rd_ and wr_ both low in IDLE.
  - Required: bus_err=1 for one clock, no RAM change, ready=1.
- Reset mid-WAIT (WAITST=3): assert rst_ low in the second wait clock.
  - Required: ready=1 and ad_oe=0 immediately (asynchronous); RAM contents preserved.
- WPROT build: write 0x77 to 0x0400.
  - Required: bus_err pulse on commit, mem[0x400] unchanged. A write to 0x0900 is stored.
